// File: rtl/hazard_pkg.sv
// Shared encodings for the MINI-RISC hazard controller.
package hazard_pkg;

  // write_mode encodings (E and W stages)
  localparam logic [1:0] WM_NONE = 2'b00;
  localparam logic [1:0] WM_RD   = 2'b01;
  localparam logic [1:0] WM_PAIR = 2'b10;

  // E-stage operand source selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W0 = 2'b01;
  localparam logic [1:0] FWD_W1 = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LSTALL = 2'b01,
    ST_FLUSH  = 2'b10,
    ST_HALT   = 2'b11
  } hz_state_e;

  // True when a writer with destination rd and mode wm produces register rs.
  // A pair write also produces rd+1, wrapping modulo 8.
  function automatic logic reg_hit(input logic [2:0] rs, input logic [2:0] rd,
                                   input logic [1:0] wm);
    return ((wm != WM_NONE) && (rs == rd)) ||
           ((wm == WM_PAIR) && (rs == 3'(rd + 3'd1)));
  endfunction

  // Operand select: the primary destination wins over the pair's second half.
  function automatic logic [1:0] fwd_sel(input logic [2:0] rs, input logic [2:0] rd,
                                         input logic [1:0] wm);
    if ((wm != WM_NONE) && (rs == rd))             return FWD_W0;
    else if ((wm == WM_PAIR) && (rs == 3'(rd + 3'd1))) return FWD_W1;
    else                                           return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Count up on inc, hold once all ones is reached.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding control for the F/D/E/W MINI-RISC pipeline.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       rs1_D,
  input  logic [2:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic [2:0]       rd_E,
  input  logic [1:0]       write_mode_E,
  input  logic             mem_read_E,
  input  logic             branch_taken_E,
  input  logic [2:0]       rs1_E,
  input  logic [2:0]       rs2_E,
  input  logic [2:0]       rd_W,
  input  logic [1:0]       write_mode_W,
  input  logic             halt_req,
  output logic             stall_F,
  output logic             flush_F,
  output logic             flush_D,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stall_c, flush_f_c, flush_d_c;
  logic       load_use;

  assign load_use = mem_read_E &
                    ((rs1_used_D & reg_hit(rs1_D, rd_E, write_mode_E)) |
                     (rs2_used_D & reg_hit(rs2_D, rd_E, write_mode_E)));

  // Next state and raw controls; a taken branch overrides every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    flush_f_c = 1'b0;
    flush_d_c = 1'b0;
    if (branch_taken_E) begin
      flush_f_c = 1'b1;
      flush_d_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = 4'(FLUSH_CYCLES - 1);
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            stall_c   = 1'b1;
            flush_d_c = 1'b1;
            state_d   = ST_HALT;
          end else if (load_use) begin
            stall_c   = 1'b1;
            flush_d_c = 1'b1;
            if (LOAD_LATENCY > 1) begin
              state_d = ST_LSTALL;
              cnt_d   = 4'(LOAD_LATENCY - 1);
            end
          end
        end
        ST_LSTALL: begin
          stall_c   = 1'b1;
          flush_d_c = 1'b1;
          if (cnt_q == 4'd1) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_FLUSH: begin
          flush_f_c = 1'b1;
          if (cnt_q == 4'd1) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_HALT: begin
          if (halt_req) begin
            stall_c   = 1'b1;
            flush_d_c = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM state and residual cycle count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is held; flush beats stall.
  assign flush_F   = reset_n & flush_f_c;
  assign stall_F   = reset_n & stall_c & ~flush_f_c;
  assign flush_D   = reset_n & flush_d_c;
  assign busy      = reset_n & (state_q != ST_RUN);
  assign fwd_a_sel = {2{reset_n}} & fwd_sel(rs1_E, rd_W, write_mode_W);
  assign fwd_b_sel = {2{reset_n}} & fwd_sel(rs2_E, rd_W, write_mode_W);

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (stall_F),
    .count  (stall_count)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (branch_taken_E),
    .count  (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two parameterizations share one stimulus stream
// and are checked against a remaining-cycles reference model.
module tb_hazard_controller;

  logic       clk, reset_n;
  logic [2:0] rs1_D, rs2_D, rd_E, rs1_E, rs2_E, rd_W;
  logic       rs1_used_D, rs2_used_D, mem_read_E, branch_taken_E, halt_req;
  logic [1:0] write_mode_E, write_mode_W;

  logic       st[2], fF[2], fD[2], bz[2];
  logic [1:0] fa[2], fb[2];
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  int total = 0;
  int bad   = 0;

  // model configuration per instance
  int LL[2]   = '{1, 3};
  int FC[2]   = '{1, 2};
  int CMAX[2] = '{65535, 15};

  // model state
  int stall_left[2], flush_left[2], m_sc[2], m_fc[2];
  bit halting[2];

  // last sampled DUT values (for the hand-written checks)
  int g_st[2], g_fF[2], g_fD[2], g_bz[2], g_fa[2], g_fb[2];

  hazard_controller #(.LOAD_LATENCY(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E),
    .write_mode_E(write_mode_E), .mem_read_E(mem_read_E),
    .branch_taken_E(branch_taken_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_W(rd_W),
    .write_mode_W(write_mode_W), .halt_req(halt_req), .stall_F(st[0]),
    .flush_F(fF[0]), .flush_D(fD[0]), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
    .busy(bz[0]), .stall_count(sc_a), .flush_count(fc_a));

  hazard_controller #(.LOAD_LATENCY(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_b (
    .clk(clk), .reset_n(reset_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E),
    .write_mode_E(write_mode_E), .mem_read_E(mem_read_E),
    .branch_taken_E(branch_taken_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_W(rd_W),
    .write_mode_W(write_mode_W), .halt_req(halt_req), .stall_F(st[1]),
    .flush_F(fF[1]), .flush_D(fD[1]), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
    .busy(bz[1]), .stall_count(sc_b), .flush_count(fc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d expected=%0d at %0t", name, idx, got, exp, $time);
    end
  endtask

  function automatic int mfwd(input int rs, input int rd, input int wm);
    if (wm != 0 && rs == rd) return 1;
    if (wm == 2 && rs == (rd + 1) % 8) return 2;
    return 0;
  endfunction

  function automatic bit m_load_use();
    int r1 = rs1_D, r2 = rs2_D, rd = rd_E, wm = write_mode_E;
    bit hit1 = (r1 == rd) || (wm == 2 && r1 == (rd + 1) % 8);
    bit hit2 = (r2 == rd) || (wm == 2 && r2 == (rd + 1) % 8);
    return mem_read_E && wm != 0 && ((rs1_used_D && hit1) || (rs2_used_D && hit2));
  endfunction

  // One cycle of the model: pending flush cycles, then pending stall cycles,
  // then an ongoing halt, then new requests; a taken branch preempts all.
  task automatic eval(input int i, output bit e_st, output bit e_fF, output bit e_fD,
                      output bit e_bz, output int nsl, output int nfl, output bit nh);
    nsl = stall_left[i]; nfl = flush_left[i]; nh = halting[i];
    e_st = 0; e_fF = 0; e_fD = 0;
    e_bz = (stall_left[i] > 0) || (flush_left[i] > 0) || halting[i];
    if (branch_taken_E) begin
      e_fF = 1; e_fD = 1; nfl = FC[i] - 1; nsl = 0; nh = 0;
    end else if (flush_left[i] > 0) begin
      e_fF = 1; nfl--;
    end else if (stall_left[i] > 0) begin
      e_st = 1; e_fD = 1; nsl--;
    end else if (halting[i]) begin
      if (halt_req) begin e_st = 1; e_fD = 1; end
      else nh = 0;
    end else if (halt_req) begin
      e_st = 1; e_fD = 1; nh = 1;
    end else if (m_load_use()) begin
      e_st = 1; e_fD = 1; nsl = LL[i] - 1;
    end
  endtask

  // Inputs are set before calling; compare, then advance model across posedge.
  task automatic cyc();
    bit e_st, e_fF, e_fD, e_bz;
    bit est[2], nh[2];
    int nsl[2], nfl[2];
    #1;
    for (int i = 0; i < 2; i++) begin
      eval(i, e_st, e_fF, e_fD, e_bz, nsl[i], nfl[i], nh[i]);
      est[i] = e_st;
      g_st[i] = int'(st[i]); g_fF[i] = int'(fF[i]); g_fD[i] = int'(fD[i]);
      g_bz[i] = int'(bz[i]); g_fa[i] = int'(fa[i]); g_fb[i] = int'(fb[i]);
      chk("stall_F", i, g_st[i], int'(e_st));
      chk("flush_F", i, g_fF[i], int'(e_fF));
      chk("flush_D", i, g_fD[i], int'(e_fD));
      chk("busy",    i, g_bz[i], int'(e_bz));
      chk("fwd_a",   i, g_fa[i], mfwd(rs1_E, rd_W, write_mode_W));
      chk("fwd_b",   i, g_fb[i], mfwd(rs2_E, rd_W, write_mode_W));
      chk("stall_count", i, (i == 0) ? int'(sc_a) : int'(sc_b), m_sc[i]);
      chk("flush_count", i, (i == 0) ? int'(fc_a) : int'(fc_b), m_fc[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (est[i] && m_sc[i] < CMAX[i]) m_sc[i]++;
      if (branch_taken_E && m_fc[i] < CMAX[i]) m_fc[i]++;
      stall_left[i] = nsl[i]; flush_left[i] = nfl[i]; halting[i] = nh[i];
    end
    @(negedge clk);
  endtask

  task automatic clear_in();
    rs1_D = 0; rs2_D = 0; rs1_used_D = 0; rs2_used_D = 0; rd_E = 0;
    write_mode_E = 0; mem_read_E = 0; branch_taken_E = 0; rs1_E = 0; rs2_E = 0;
    rd_W = 0; write_mode_W = 0; halt_req = 0;
  endtask

  // Async reset at a negedge: everything must read zero at once.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_stall_F", i, int'(st[i]), 0);
      chk("rst_flush_F", i, int'(fF[i]), 0);
      chk("rst_flush_D", i, int'(fD[i]), 0);
      chk("rst_busy",    i, int'(bz[i]), 0);
      chk("rst_fwd",     i, int'({fa[i], fb[i]}), 0);
      chk("rst_counts",  i, (i == 0) ? int'(sc_a) + int'(fc_a) : int'(sc_b) + int'(fc_b), 0);
      stall_left[i] = 0; flush_left[i] = 0; halting[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_load_r3();
    mem_read_E = 1; write_mode_E = 2'b01; rd_E = 3'd3; rs1_D = 3'd3; rs1_used_D = 1;
  endtask

  typedef struct {
    logic [2:0] rs1, rs2, rd;
    logic [1:0] wm, ea, eb;
  } fvec_t;
  fvec_t tbl[6];

  initial begin
    tbl[0] = '{3'd0, 3'd7, 3'd7, 2'd2, 2'd2, 2'd1};  // pair wrap-around
    tbl[1] = '{3'd3, 3'd4, 3'd3, 2'd1, 2'd1, 2'd0};
    tbl[2] = '{3'd4, 3'd3, 3'd3, 2'd2, 2'd2, 2'd1};
    tbl[3] = '{3'd3, 3'd3, 3'd3, 2'd0, 2'd0, 2'd0};  // no write
    tbl[4] = '{3'd5, 3'd6, 3'd5, 2'd3, 2'd1, 2'd0};  // mode 11: no pair half
    tbl[5] = '{3'd1, 3'd2, 3'd6, 2'd2, 2'd0, 2'd0};

    clear_in();
    reset_n = 1'b0;
    @(negedge clk);
    do_reset();

    // load-use, LOAD_LATENCY=1, then forward from W
    set_load_r3();
    cyc();
    chk("lu1_stall", 0, g_st[0], 1); chk("lu1_flushD", 0, g_fD[0], 1);
    clear_in(); rd_W = 3'd3; write_mode_W = 2'b01; rs1_E = 3'd3;
    cyc();
    chk("lu1_fwd_a", 0, g_fa[0], 1); chk("lu1_nostall", 0, g_st[0], 0);

    // load-use, LOAD_LATENCY=3
    clear_in(); do_reset();
    set_load_r3();
    cyc(); chk("lu3_st_c1", 1, g_st[1], 1); chk("lu3_bz_c1", 1, g_bz[1], 0);
    clear_in();
    cyc(); chk("lu3_st_c2", 1, g_st[1], 1); chk("lu3_bz_c2", 1, g_bz[1], 1);
    cyc(); chk("lu3_st_c3", 1, g_st[1], 1); chk("lu3_bz_c3", 1, g_bz[1], 1);
    cyc(); chk("lu3_st_c4", 1, g_st[1], 0); chk("lu3_bz_c4", 1, g_bz[1], 0);
    chk("lu3_count", 1, int'(sc_b), 3);

    // branch with simultaneous load-use, FLUSH_CYCLES=2
    do_reset();
    set_load_r3(); branch_taken_E = 1;
    cyc();
    chk("br_c0_fF", 1, g_fF[1], 1); chk("br_c0_fD", 1, g_fD[1], 1); chk("br_c0_st", 1, g_st[1], 0);
    clear_in();
    cyc();
    chk("br_c1_fF", 1, g_fF[1], 1); chk("br_c1_fD", 1, g_fD[1], 0); chk("br_c1_st", 1, g_st[1], 0);
    cyc();
    chk("br_c2_fF", 1, g_fF[1], 0);
    chk("br_count", 1, int'(fc_b), 1);

    // forwarding table
    do_reset();
    foreach (tbl[k]) begin
      clear_in();
      rs1_E = tbl[k].rs1; rs2_E = tbl[k].rs2; rd_W = tbl[k].rd; write_mode_W = tbl[k].wm;
      cyc();
      chk("tbl_a", k, g_fa[1], int'(tbl[k].ea));
      chk("tbl_b", k, g_fb[1], int'(tbl[k].eb));
    end

    // halt held 4 cycles
    clear_in(); do_reset();
    halt_req = 1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("halt_st", c, g_st[0] + g_st[1], 2);
      chk("halt_fD", c, g_fD[0] + g_fD[1], 2);
    end
    halt_req = 0;
    cyc(); chk("halt_rel_st", 0, g_st[0] + g_st[1], 0); chk("halt_rel_bz", 0, g_bz[0], 1);
    cyc(); chk("halt_run_bz", 0, g_bz[0] + g_bz[1], 0);

    // halt with a branch in its third cycle
    do_reset();
    halt_req = 1;
    cyc(); cyc();
    branch_taken_E = 1;
    cyc();
    chk("halt_br_fF", 0, g_fF[0] + g_fF[1], 2); chk("halt_br_st", 0, g_st[0] + g_st[1], 0);
    branch_taken_E = 0;
    cyc();
    halt_req = 0;
    cyc(); cyc(); cyc();

    // reset in the middle of LSTALL, then saturation with CNT_W=4
    do_reset();
    set_load_r3(); rd_W = 3'd3; write_mode_W = 2'b01; rs1_E = 3'd3;
    cyc(); cyc();
    chk("mid_lstall_bz", 1, g_bz[1], 1);
    do_reset();
    for (int c = 0; c < 20; c++) cyc();
    chk("sat_b", 1, int'(sc_b), 15);
    chk("sat_a", 0, int'(sc_a), 20);

    // randomized traffic against the model
    clear_in(); do_reset();
    for (int c = 0; c < 600; c++) begin
      rs1_D = 3'($urandom_range(0, 7)); rs2_D = 3'($urandom_range(0, 7));
      rs1_used_D = ($urandom_range(0, 3) != 0); rs2_used_D = ($urandom_range(0, 3) != 0);
      rd_E = 3'($urandom_range(0, 7)); write_mode_E = 2'($urandom_range(0, 3));
      mem_read_E = ($urandom_range(0, 1) != 0);
      branch_taken_E = ($urandom_range(0, 9) == 0);
      halt_req = ($urandom_range(0, 11) == 0) || (halt_req && $urandom_range(0, 2) != 0);
      rs1_E = 3'($urandom_range(0, 7)); rs2_E = 3'($urandom_range(0, 7));
      rd_W = 3'($urandom_range(0, 7)); write_mode_W = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
